inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-006 SHALL have port imem_addr  out  32  fetch address, always word-aligned.
REQ-007 SHALL have port imem_rsp_valid  in  1  instruction word returned.
REQ-008 SHALL have port imem_rsp_data  in  32  returned instruction word.
REQ-009 SHALL have port redirect_valid  in  1  branch/jump redirect, single-cycle pulse.
REQ-010 SHALL have port redirect_pc  in  32  redirect target.
REQ-011 SHALL have port inst_valid  out  1  instruction available to decoder.
REQ-012 SHALL have port inst_ready  in  1  decoder consumes instruction.
REQ-013 SHALL have port inst  out  32  instruction word to decoder.
REQ-014 SHALL have port inst_pc  out  32  PC of inst.

Function
REQ-015 SHALL implement FSM IDLE, REQ, WAIT, HOLD, with at most one outstanding memory request.
REQ-016 IDLE SHALL go to REQ on the first clock edge after reset release, with all outputs deasserted.
REQ-017 REQ SHALL assert imem_req_valid with imem_addr=pc, and go to WAIT on the edge where imem_req_ready=1.
REQ-018 imem_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect occurs.
REQ-019 WAIT SHALL, on imem_rsp_valid=1, register imem_rsp_data into inst and pc into inst_pc, and go to HOLD.
REQ-020 HOLD SHALL assert inst_valid, holding inst and inst_pc stable until inst_ready=1.
REQ-021 On inst_ready=1 in HOLD, pc SHALL become pc+4 (mod 2^32, wraps) and the FSM SHALL go to REQ; fetch-to-fetch latency is 3 cycles with zero-wait memory.
REQ-022 redirect_valid SHALL load pc with {redirect_pc[31:2],2'b00}, and the low two bits SHALL be ignored.
REQ-023 In REQ, a redirect without ready SHALL update imem_addr next cycle; a redirect with ready in the same cycle SHALL have the old request accepted and a drop flag set.
REQ-024 In WAIT, a redirect SHALL set the drop flag; the response that arrives with drop set SHALL be discarded, drop SHALL clear, and the FSM SHALL return to REQ with the new pc.
REQ-025 Redirect and imem_rsp_valid in the same WAIT cycle SHALL discard the response.
REQ-026 In HOLD, a redirect SHALL deassert inst_valid the next cycle and go to REQ; redirect SHALL win over a simultaneous inst_ready (pc = target, not pc+4).
REQ-027 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-028 Redirects in IDLE SHALL update pc; the first fetch then uses the target.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, pc=RESET_PC, drop=0, imem_req_valid=0, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC.
REQ-030 Reset mid-transaction SHALL abandon any outstanding request; the memory model is reset by the same rst.

Structure
REQ-031 State encodings, RESET_PC default and the NOP encoding SHALL live in the shared defines file; the inst width SHALL use the existing RegBus macro.
REQ-032 The PC register plus next-PC mux (redirect / +4 / hold) SHALL be a sub-module pc_reg; the FSM and buffer SHALL stay in inst_fetch.

Verification
REQ-033 Reset release, zero-wait memory, inst_ready=1 always -> inst_pc sequence 80000000, 80000004, 80000008, one instruction every 3 cycles.
REQ-034 imem_req_ready low 4 cycles -> imem_addr held at 80000000 throughout; inst delivered with correct data afterwards.
REQ-035 inst_ready low 5 cycles in HOLD -> inst and inst_pc constant, no new request issued; on release, next fetch addr = +4.
REQ-036 Redirect to 80001002 during WAIT -> in-flight word dropped (never shows inst_valid); next request addr 80001000; inst_pc 80001000.
REQ-037 Redirect and inst_ready in the same HOLD cycle -> next imem_addr = target, not pc+4.
REQ-038 rst asserted during WAIT, then released -> outputs reset immediately; first request at 80000000, stale response ignored.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, reset PC,
// NOP encoding and FSM state encodings.
package inst_fetch_pkg;

    localparam int unsigned RegBus = 32;

    localparam logic [31:0]        ResetPcDefault = 32'h8000_0000;
    localparam logic [RegBus-1:0]  NopInst        = 32'h0000_0013;

    // Clears the byte offset of a target so fetch addresses stay word-aligned.
    localparam logic [31:0]        WordMask       = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register with next-PC selection: redirect beats advance,
// advance adds 4 (wrapping), otherwise hold.
module pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPcDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    // Next-PC mux.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & WordMask;
        end else if (advance) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC & WordMask;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one memory request at a time, buffers the
// returned word for the decoder, and discards responses made stale by a redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPcDefault
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [RegBus-1:0] inst,
    output logic [31:0]       inst_pc
);

    fetch_state_e      state_d, state_q;
    logic              drop_d, drop_q;
    logic [RegBus-1:0] inst_d, inst_q;
    logic [31:0]       inst_pc_d, inst_pc_q;
    logic              advance;
    logic [31:0]       pc;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc             (pc)
    );

    // Next-state, drop-flag and instruction buffer update.
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        advance   = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (imem_req_ready) begin
                    state_d = StWait;
                    // Old address was accepted; its response must not reach decode.
                    if (redirect_valid) begin
                        drop_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc;
                        state_d   = StHold;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    state_d = StReq;
                end else if (inst_ready) begin
                    advance = 1'b1;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            drop_q    <= 1'b0;
            inst_q    <= NopInst;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign imem_req_valid = (state_q == StReq);
    assign imem_addr      = pc;
    assign inst_valid     = (state_q == StHold);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a zero-wait memory model that can be
// switched off for hand-driven responses.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_checks;
    int n_pass;
    logic mem_en;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock; memory answers the cycle after a handshake when enabled.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready && !rst;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (mem_en) begin
            imem_rsp_valid = acc;
            imem_rsp_data  = acc ? mem_word(a) : 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h8000_0000);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Starting in REQ with ready/inst_ready high: one fetch takes exactly 3 cycles.
    task automatic fetch_one(input logic [31:0] exp_pc);
        check("f_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("f_addr", imem_addr, exp_pc);
        cyc();
        check("f_wait_no_inst", {31'h0, inst_valid}, 32'h0);
        cyc();
        check("f_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("f_inst_pc", inst_pc, exp_pc);
        check("f_inst", inst, mem_word(exp_pc));
        cyc();
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        mem_en         = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;

        // Streaming with zero-wait memory.
        do_reset();
        check("idle_no_req", {31'h0, imem_req_valid}, 32'h0);
        cyc();
        fetch_one(32'h8000_0000);
        fetch_one(32'h8000_0004);
        fetch_one(32'h8000_0008);

        // Request back-pressure: address must hold.
        do_reset();
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            check("bp_req_valid", {31'h0, imem_req_valid}, 32'h1);
            check("bp_addr", imem_addr, 32'h8000_0000);
            cyc();
        end
        imem_req_ready = 1'b1;
        cyc();
        cyc();
        check("bp_inst", inst, mem_word(32'h8000_0000));

        // Decoder stall in HOLD.
        for (int i = 0; i < 5; i++) begin
            check("stall_inst_valid", {31'h0, inst_valid}, 32'h1);
            check("stall_inst", inst, mem_word(32'h8000_0000));
            check("stall_inst_pc", inst_pc, 32'h8000_0000);
            check("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
            cyc();
        end
        inst_ready = 1'b1;
        cyc();
        check("stall_next_addr", imem_addr, 32'h8000_0004);

        // Redirect while waiting: in-flight word is dropped.
        mem_en = 1'b0;
        cyc();
        pulse_redirect(32'h8000_1002);
        check("wr_no_inst", {31'h0, inst_valid}, 32'h0);
        check("wr_no_req", {31'h0, imem_req_valid}, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        cyc();
        imem_rsp_valid = 1'b0;
        check("wr_drop_no_inst", {31'h0, inst_valid}, 32'h0);
        mem_en = 1'b1;
        fetch_one(32'h8000_1000);

        // Redirect colliding with the response in WAIT.
        cyc();
        pulse_redirect(32'h8000_2000);
        check("col_no_inst", {31'h0, inst_valid}, 32'h0);
        fetch_one(32'h8000_2000);

        // Redirect beats inst_ready in HOLD.
        cyc();
        cyc();
        check("hold_inst_pc", inst_pc, 32'h8000_2004);
        pulse_redirect(32'h8000_3000);
        check("hold_rd_no_inst", {31'h0, inst_valid}, 32'h0);
        check("hold_rd_addr", imem_addr, 32'h8000_3000);

        // Redirect with accept in REQ: old response discarded.
        pulse_redirect(32'h8000_4000);
        cyc();
        check("reqacc_no_inst", {31'h0, inst_valid}, 32'h0);
        check("reqacc_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("reqacc_addr", imem_addr, 32'h8000_4000);

        // Redirect without accept in REQ retargets the pending request.
        imem_req_ready = 1'b0;
        pulse_redirect(32'h8000_5001);
        check("reqnr_addr", imem_addr, 32'h8000_5000);
        imem_req_ready = 1'b1;
        fetch_one(32'h8000_5000);

        // Reset while a request is outstanding; stale response ignored.
        mem_en = 1'b0;
        cyc();
        do_reset();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        imem_req_ready = 1'b0;
        cyc();
        check("stale_addr", imem_addr, 32'h8000_0000);
        cyc();
        check("stale_no_inst", {31'h0, inst_valid}, 32'h0);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        mem_en         = 1'b1;
        fetch_one(32'h8000_0000);

        // Redirect in IDLE, then PC wrap past 2^32.
        do_reset();
        pulse_redirect(32'hFFFF_FFFE);
        fetch_one(32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
